// File: rtl/quad_step_decoder.sv
// Quadrature encoder decoder: synchronizes and filters A/B, emits one-cycle up/down strobes,
// mirrors position/direction and keeps a sticky illegal-transition flag. QUAD_INDEX_EN adds enc_z.
module quad_step_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int POS_WIDTH   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enc_a,
    input  logic                 enc_b,
`ifdef QUAD_INDEX_EN
    input  logic                 enc_z,
`endif
    input  logic                 enable,
    input  logic                 err_clr,
    output logic                 up,
    output logic                 down,
    output logic [POS_WIDTH-1:0] position,
    output logic                 dir,
    output logic                 err
);

`ifdef QUAD_INDEX_EN
    localparam int NCH = 3;
`else
    localparam int NCH = 2;
`endif
    localparam int CW = $clog2(FILTER_LEN + 1);
    localparam int IW = $clog2(SYNC_STAGES + 1);

    typedef enum logic {S_INIT, S_TRACK} state_t;

    state_t                              state_q, state_d;
    logic [IW-1:0]                       init_cnt_q, init_cnt_d;
    logic [SYNC_STAGES-1:0][NCH-1:0]     sync_q, sync_d;
    logic [NCH-1:0][CW-1:0]              cnt_q, cnt_d;
    logic [NCH-1:0]                      filt_q, filt_d;
    logic [NCH-1:0]                      prev_q, prev_d;
    logic                                up_q, up_d;
    logic                                down_q, down_d;
    logic [POS_WIDTH-1:0]                pos_q, pos_d;
    logic                                dir_q, dir_d;
    logic                                err_q, err_d;

    logic [NCH-1:0] raw;
    logic [NCH-1:0] synced;
    logic [1:0]     delta;
    logic           err_set;

    // Channel bit order: [1]=A, [0]=B, [2]=Z when present.
`ifdef QUAD_INDEX_EN
    assign raw = {enc_z, enc_a, enc_b};
`else
    assign raw = {enc_a, enc_b};
`endif
    assign synced = sync_q[SYNC_STAGES-1];

    // Gray {A,B} to a 2-bit phase: 00->0, 01->1, 11->2, 10->3.
    function automatic logic [1:0] phase_of(input logic [1:0] g);
        return {g[1], g[1] ^ g[0]};
    endfunction

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        cnt_d      = cnt_q;
        filt_d     = filt_q;
        prev_d     = prev_q;
        up_d       = 1'b0;
        down_d     = 1'b0;
        pos_d      = pos_q;
        dir_d      = dir_q;
        err_set    = 1'b0;
        delta      = phase_of(filt_q[1:0]) - phase_of(prev_q[1:0]);
        sync_d[0]  = raw;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end

        case (state_q)
            S_INIT: begin
                // Chains hold reset values until SYNC_STAGES samples have shifted through.
                if (init_cnt_q == IW'(SYNC_STAGES)) begin
                    state_d = S_TRACK;
                    filt_d  = synced;
                    prev_d  = synced;
                end else begin
                    init_cnt_d = init_cnt_q + IW'(1);
                end
            end
            default: begin
                for (int c = 0; c < NCH; c++) begin
                    if (synced[c] != filt_q[c]) begin
                        if (cnt_q[c] == CW'(FILTER_LEN - 1)) begin
                            filt_d[c] = synced[c];
                            cnt_d[c]  = '0;
                        end else begin
                            cnt_d[c] = cnt_q[c] + CW'(1);
                        end
                    end else begin
                        cnt_d[c] = '0;
                    end
                end
                prev_d = filt_q;
                case (delta)
                    2'd1: if (enable) begin
                        up_d  = 1'b1;
                        pos_d = pos_q + POS_WIDTH'(1);
                        dir_d = 1'b1;
                    end
                    2'd3: if (enable) begin
                        down_d = 1'b1;
                        pos_d  = pos_q - POS_WIDTH'(1);
                        dir_d  = 1'b0;
                    end
                    2'd2:    err_set = 1'b1;
                    default: ;
                endcase
`ifdef QUAD_INDEX_EN
                if (filt_q[2] && !prev_q[2]) begin
                    pos_d = '0;
                end
`endif
            end
        endcase

        err_d = err_set | (err_q & ~err_clr);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_INIT;
            init_cnt_q <= '0;
            sync_q     <= '0;
            cnt_q      <= '0;
            filt_q     <= '0;
            prev_q     <= '0;
            up_q       <= 1'b0;
            down_q     <= 1'b0;
            pos_q      <= '0;
            dir_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            sync_q     <= sync_d;
            cnt_q      <= cnt_d;
            filt_q     <= filt_d;
            prev_q     <= prev_d;
            up_q       <= up_d;
            down_q     <= down_d;
            pos_q      <= pos_d;
            dir_q      <= dir_d;
            err_q      <= err_d;
        end
    end

    assign up       = up_q;
    assign down     = down_q;
    assign position = pos_q;
    assign dir      = dir_q;
    assign err      = err_q;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Bench for quad_step_decoder: drives quadrature steps, queues expected {up,down,position}
// per step and compares each strobe as it appears; QUAD_INDEX_EN adds index-pulse checks.
module tb_quad_step_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       enc_a, enc_b;
`ifdef QUAD_INDEX_EN
    logic       enc_z;
`endif
    logic       enable, err_clr;
    logic       up, down, dir, err;
    logic [3:0] position;

    int errors = 0;
    int checks = 0;
    int up_cnt = 0;
    int down_cnt = 0;

    logic [5:0] exp_q[$];
    logic [3:0] exp_pos = 4'd0;
    logic       exp_dir = 1'b0;
    logic [1:0] cur_idx = 2'd0;
    logic       zero_next = 1'b0;
    logic [1:0] gray_tab [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    quad_step_decoder #(.SYNC_STAGES(2), .FILTER_LEN(4), .POS_WIDTH(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .enc_a    (enc_a),
        .enc_b    (enc_b),
`ifdef QUAD_INDEX_EN
        .enc_z    (enc_z),
`endif
        .enable   (enable),
        .err_clr  (err_clr),
        .up       (up),
        .down     (down),
        .position (position),
        .dir      (dir),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (up === 1'b1 || down === 1'b1) begin
            if (up) up_cnt++;
            if (down) down_cnt++;
            if (exp_q.size() == 0)
                check("unexpected_strobe", 32'({up, down}), 32'd0);
            else
                check("strobe", 32'({up, down, position}), 32'(exp_q.pop_front()));
        end
    end

    // Called at a negedge; drives one gray step and holds it 10 cycles.
    task automatic do_step(input bit fwd, output int lat);
        cur_idx = fwd ? cur_idx + 2'd1 : cur_idx - 2'd1;
        if (enable) begin
            exp_pos = fwd ? exp_pos + 4'd1 : exp_pos - 4'd1;
            if (zero_next) exp_pos = 4'd0;
            exp_dir = fwd;
            exp_q.push_back({fwd, !fwd, exp_pos});
        end
        {enc_a, enc_b} = gray_tab[cur_idx];
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (lat == 0 && (up === 1'b1 || down === 1'b1)) lat = i;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    initial begin
        int lat;
        int up0;
        reset = 1'b0; enc_a = 1'b0; enc_b = 1'b0; enable = 1'b1; err_clr = 1'b0;
`ifdef QUAD_INDEX_EN
        enc_z = 1'b0;
`endif
        repeat (5) @(negedge clk);
        check("rst_up", 32'(up), 32'd0);
        check("rst_down", 32'(down), 32'd0);
        check("rst_pos", 32'(position), 32'd0);
        check("rst_dir", 32'(dir), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        check("idle_pos", 32'(position), 32'd0);
        check("idle_err", 32'(err), 32'd0);
        check("idle_strobes", 32'(up_cnt + down_cnt), 32'd0);

        // 16 forward steps, wrapping 15 -> 0
        for (int s = 0; s < 16; s++) begin
            do_step(1'b1, lat);
            if (s == 0) check("first_latency", 32'(lat), 32'd7);
        end
        check("fwd_up_cnt", 32'(up_cnt), 32'd16);
        check("fwd_down_cnt", 32'(down_cnt), 32'd0);
        check("fwd_pos", 32'(position), 32'(exp_pos));
        check("fwd_dir", 32'(dir), 32'd1);

        // 3 reverse steps from 0 -> 13
        for (int s = 0; s < 3; s++) begin
            do_step(1'b0, lat);
            if (s == 0) check("rev_latency", 32'(lat), 32'd7);
        end
        check("rev_down_cnt", 32'(down_cnt), 32'd3);
        check("rev_pos", 32'(position), 32'd13);
        check("rev_dir", 32'(dir), 32'd0);

        // Glitch on A shorter than the filter
        enc_a = ~enc_a;
        repeat (2) @(negedge clk);
        enc_a = ~enc_a;
        repeat (10) @(negedge clk);
        check("glitch_pos", 32'(position), 32'd13);
        check("glitch_err", 32'(err), 32'd0);
        check("glitch_strobes", 32'(up_cnt + down_cnt), 32'd19);

        // Illegal 2-bit change 01 -> 10
        cur_idx = cur_idx + 2'd2;
        {enc_a, enc_b} = gray_tab[cur_idx];
        repeat (10) @(negedge clk);
        check("illegal_err", 32'(err), 32'd1);
        check("illegal_pos", 32'(position), 32'd13);
        check("illegal_dir", 32'(dir), 32'd0);
        check("illegal_strobes", 32'(up_cnt + down_cnt), 32'd19);
        pulse_err_clr();
        check("err_cleared", 32'(err), 32'd0);

        // Illegal change with err_clr on the very edge err is set: set wins
        cur_idx = cur_idx + 2'd2;
        {enc_a, enc_b} = gray_tab[cur_idx];
        repeat (6) @(negedge clk);
        check("err_before_set", 32'(err), 32'd0);
        pulse_err_clr();
        check("err_set_wins", 32'(err), 32'd1);
        repeat (4) @(negedge clk);
        pulse_err_clr();
        check("err_cleared2", 32'(err), 32'd0);

        // Steps while disabled are tracked silently
        enable = 1'b0;
        up0 = up_cnt;
        do_step(1'b1, lat);
        do_step(1'b1, lat);
        enable = 1'b1;
        repeat (5) @(negedge clk);
        check("dis_pos", 32'(position), 32'd13);
        check("dis_strobes", 32'(up_cnt - up0), 32'd0);
        check("dis_err", 32'(err), 32'd0);
        do_step(1'b1, lat);
        check("reen_up", 32'(up_cnt - up0), 32'd1);
        check("reen_pos", 32'(position), 32'd14);

        // Reset in the middle of a filter count drops the step
        cur_idx = cur_idx + 2'd1;
        {enc_a, enc_b} = gray_tab[cur_idx];
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        exp_pos = 4'd0;
        exp_dir = 1'b0;
        repeat (12) @(negedge clk);
        check("midrst_pos", 32'(position), 32'd0);
        check("midrst_dir", 32'(dir), 32'd0);
        check("midrst_queue", 32'(exp_q.size()), 32'd0);
        up0 = up_cnt;
        do_step(1'b1, lat);
        check("post_rst_up", 32'(up_cnt - up0), 32'd1);
        check("post_rst_pos", 32'(position), 32'd1);

`ifdef QUAD_INDEX_EN
        for (int s = 0; s < 6; s++) do_step(1'b1, lat);
        check("pre_index_pos", 32'(position), 32'd7);
        enc_z = 1'b1;
        repeat (6) @(negedge clk);
        check("index_pos_before", 32'(position), 32'd7);
        @(negedge clk);
        check("index_pos_after", 32'(position), 32'd0);
        repeat (3) @(negedge clk);
        enc_z = 1'b0;
        exp_pos = 4'd0;
        repeat (10) @(negedge clk);
        check("index_fall_pos", 32'(position), 32'd0);
        do_step(1'b1, lat);
        check("index_step_pos", 32'(position), 32'd1);
        up0 = up_cnt;
        enc_z = 1'b1;
        zero_next = 1'b1;
        do_step(1'b1, lat);
        zero_next = 1'b0;
        check("coincide_up", 32'(up_cnt - up0), 32'd1);
        check("coincide_pos", 32'(position), 32'd0);
        enc_z = 1'b0;
        repeat (10) @(negedge clk);
`endif

        check("final_dir", 32'(dir), 32'(exp_dir));
        check("final_queue", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
